// File: rtl/ram_responder.sv
// ram_responder -- program RAM with a streaming loader front end.
//
// After reset the block sits in LOAD: it accepts 16-bit program words from a
// valid/ready loader stream and writes them to consecutive addresses starting
// at 0, while holding the CPU in reset. A word flagged load_last, or a word
// that fills the final location, ends the load. START then holds cpu_rst for
// one more cycle. In RUN the CPU owns the RAM through a single word-addressed
// port with one-cycle registered reads and read-before-write behaviour.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-high reset (memory contents are kept)
//   wrEn          CPU write strobe (RUN only)
//   addr_toRAM    CPU word address, taken modulo DEPTH
//   data_toRAM    CPU write data
//   data_fromRAM  registered read data, 0 outside RUN
//   load_valid    loader word valid (LOAD only)
//   load_data     loader program word
//   load_last     final loader word, qualified by load_valid
//   load_ready    high while the loader may hand over words
//   cpu_rst       reset for the CPU, released on entry to RUN
//   load_count    words accepted in the current load, saturating at DEPTH
//   load_err      sticky: the load filled DEPTH words without load_last
module ram_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn,
    input  logic [AW-1:0] addr_toRAM,
    input  logic [15:0]   data_toRAM,
    output logic [15:0]   data_fromRAM,
    input  logic          load_valid,
    input  logic [15:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          cpu_rst,
    output logic [AW:0]   load_count,
    output logic          load_err
);

    // Index width into the memory; DEPTH is a power of two no larger than
    // 2**AW, so the low IW address bits select the word and the rest wrap.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [AW:0]   COUNT_MAX = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [IW-1:0]   ptr_r;
    logic [AW:0]     count_r;
    logic            err_r;
    logic [15:0]     rdata_r;
    logic            ready_r;
    logic            cpu_rst_r;

    logic            hs_s;
    logic            err_set_s;
    logic            cpu_wr_s;
    logic [IW-1:0]   cpu_idx_s;
    logic            addr_hi_unused_s;

    // Zero power-up content so words never written read back as 0; rst does
    // not touch this array.
    logic [15:0]     mem_r [DEPTH] = '{default: 16'h0000};

    assign cpu_idx_s        = addr_toRAM[IW-1:0];
    assign addr_hi_unused_s = ^addr_toRAM;
    assign cpu_wr_s         = (state_r == ST_RUN) && wrEn;

    // Next-state logic and loader handshake decode.
    always_comb begin
        state_nx_s = state_r;
        hs_s       = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (load_valid) begin
                    hs_s = 1'b1;
                    if (load_last) begin
                        state_nx_s = ST_START;
                    end else if (ptr_r == LAST_IDX) begin
                        // Memory is full and the stream has not ended.
                        state_nx_s = ST_START;
                        err_set_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_LOAD;
                    end
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_START: begin
                state_nx_s = ST_RUN;
            end
            ST_RUN: begin
                state_nx_s = ST_RUN;
            end
            default: begin
                state_nx_s = ST_LOAD;
            end
        endcase
    end

    // State, load bookkeeping, registered read data and registered status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_LOAD;
            ptr_r     <= {IW{1'b0}};
            count_r   <= {(AW + 1){1'b0}};
            err_r     <= 1'b0;
            rdata_r   <= 16'h0000;
            ready_r   <= 1'b1;
            cpu_rst_r <= 1'b1;
        end else begin
            state_r   <= state_nx_s;
            ready_r   <= (state_nx_s == ST_LOAD);
            cpu_rst_r <= (state_nx_s != ST_RUN);
            if (hs_s) begin
                ptr_r <= ptr_r + {{(IW - 1){1'b0}}, 1'b1};
                if (count_r != COUNT_MAX) begin
                    count_r <= count_r + {{AW{1'b0}}, 1'b1};
                end
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            // Reads see the pre-edge contents, so a same-edge write to the
            // same word returns the old value.
            if (state_r == ST_RUN) begin
                rdata_r <= mem_r[cpu_idx_s];
            end else begin
                rdata_r <= 16'h0000;
            end
        end
    end

    // Memory write port, shared between the loader and the CPU; blocked
    // while rst is held so an aborted load cannot write.
    always_ff @(posedge clk) begin
        if (!rst && hs_s) begin
            mem_r[ptr_r] <= load_data;
        end else if (!rst && cpu_wr_s) begin
            mem_r[cpu_idx_s] <= data_toRAM;
        end
    end

    assign data_fromRAM = rdata_r;
    assign load_ready   = ready_r;
    assign cpu_rst      = cpu_rst_r;
    assign load_count   = count_r;
    assign load_err     = err_r;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

    localparam int DEPTH = 16;
    localparam int AW    = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrEn;
    logic [AW-1:0] addr_toRAM;
    logic [15:0]   data_toRAM;
    logic [15:0]   data_fromRAM;
    logic          load_valid;
    logic [15:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          cpu_rst;
    logic [AW:0]   load_count;
    logic          load_err;

    int checks = 0;
    int errors = 0;

    ram_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM),
        .data_fromRAM (data_fromRAM),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .cpu_rst      (cpu_rst),
        .load_count   (load_count),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one loader word and let one edge take it.
    task automatic load_word(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // RUN-mode read: address in cycle n, data checked in cycle n+1.
    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [15:0] exp);
        addr_toRAM = a;
        wrEn       = 1'b0;
        step();
        chk(tag, {16'h0, data_fromRAM}, {16'h0, exp});
    endtask

    initial begin
        rst        = 1'b1;
        wrEn       = 1'b0;
        addr_toRAM = '0;
        data_toRAM = 16'h0000;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        load_last  = 1'b0;
        #1;
        chk("rst_ready",  {31'h0, load_ready}, 32'h1);
        chk("rst_cpurst", {31'h0, cpu_rst}, 32'h1);
        chk("rst_count",  {18'h0, load_count}, 32'h0);
        chk("rst_err",    {31'h0, load_err}, 32'h0);
        chk("rst_data",   {16'h0, data_fromRAM}, 32'h0);
        step();
        step();
        rst = 1'b0;

        // Load and start.
        load_word(16'h2005, 1'b0);
        chk("load1_count", {18'h0, load_count}, 32'd1);
        chk("load1_ready", {31'h0, load_ready}, 32'h1);
        load_word(16'hE000, 1'b0);
        load_word(16'h1234, 1'b1);
        chk("start_count",  {18'h0, load_count}, 32'd3);
        chk("start_cpurst", {31'h0, cpu_rst}, 32'h1);
        chk("start_ready",  {31'h0, load_ready}, 32'h0);
        chk("start_err",    {31'h0, load_err}, 32'h0);
        step();
        chk("run_cpurst", {31'h0, cpu_rst}, 32'h0);
        chk("run_ready",  {31'h0, load_ready}, 32'h0);
        chk("run_count",  {18'h0, load_count}, 32'd3);

        // Read latency, back to back.
        rd("rd_addr2", 13'd2, 16'h1234);
        rd("rd_addr1", 13'd1, 16'hE000);
        rd("rd_addr0", 13'd0, 16'h2005);

        // Write collision: old word returned, new word on next read.
        addr_toRAM = 13'd5;
        data_toRAM = 16'hBEEF;
        wrEn       = 1'b1;
        step();
        wrEn = 1'b0;
        chk("wr_collide_old", {16'h0, data_fromRAM}, 32'h0000);
        step();
        chk("wr_collide_new", {16'h0, data_fromRAM}, 32'h0000BEEF);

        // Loader inputs are ignored in RUN.
        load_valid = 1'b1;
        load_data  = 16'h5555;
        addr_toRAM = 13'd3;
        #1;
        chk("run_ign_ready", {31'h0, load_ready}, 32'h0);
        step();
        step();
        load_valid = 1'b0;
        chk("run_ign_count", {18'h0, load_count}, 32'd3);
        rd("run_ign_addr3", 13'd3, 16'h0000);
        rd("run_ign_addr0", 13'd0, 16'h2005);

        // Asynchronous reset in RUN, between edges.
        rst = 1'b1;
        #1;
        chk("arst_cpurst", {31'h0, cpu_rst}, 32'h1);
        chk("arst_ready",  {31'h0, load_ready}, 32'h1);
        chk("arst_count",  {18'h0, load_count}, 32'h0);
        chk("arst_data",   {16'h0, data_fromRAM}, 32'h0);
        step();
        rst = 1'b0;

        // Reset mid-load after 2 of 4 words, then reload one word.
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        chk("midload_count", {18'h0, load_count}, 32'd2);
        rst = 1'b1;
        #1;
        chk("midload_rst_count", {18'h0, load_count}, 32'h0);
        step();
        rst = 1'b0;
        load_word(16'hAAAA, 1'b1);
        chk("reload_count", {18'h0, load_count}, 32'd1);
        step();
        chk("reload_run", {31'h0, cpu_rst}, 32'h0);
        rd("reload_addr0", 13'd0, 16'hAAAA);
        rd("reload_addr1", 13'd1, 16'h2222);
        rd("reload_addr2", 13'd2, 16'h1234);
        rd("reload_addr5", 13'd5, 16'hBEEF);

        // Overflow: fill all 16 words without load_last.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            load_word(16'h0100 + 16'(i), 1'b0);
        end
        chk("ovf_pre_err",   {31'h0, load_err}, 32'h0);
        chk("ovf_pre_ready", {31'h0, load_ready}, 32'h1);
        chk("ovf_pre_count", {18'h0, load_count}, 32'd15);
        load_word(16'h010F, 1'b0);
        chk("ovf_err",    {31'h0, load_err}, 32'h1);
        chk("ovf_count",  {18'h0, load_count}, 32'd16);
        chk("ovf_cpurst", {31'h0, cpu_rst}, 32'h1);
        load_valid = 1'b1;
        load_data  = 16'h5555;
        step();
        load_valid = 1'b0;
        chk("ovf_run_cpurst", {31'h0, cpu_rst}, 32'h0);
        chk("ovf_run_count",  {18'h0, load_count}, 32'd16);
        chk("ovf_run_err",    {31'h0, load_err}, 32'h1);

        // Address wrap modulo DEPTH.
        rd("wrap_13", 13'h0013, 16'h0103);
        rd("wrap_1f", 13'h001F, 16'h010F);
        addr_toRAM = 13'h0025;
        data_toRAM = 16'h7777;
        wrEn       = 1'b1;
        step();
        wrEn = 1'b0;
        chk("wrap_wr_old", {16'h0, data_fromRAM}, 32'h0105);
        rd("wrap_rd5", 13'd5, 16'h7777);
        rd("wrap_rd0", 13'd0, 16'h0100);

        // load_err is cleared only by reset.
        rst = 1'b1;
        #1;
        chk("err_clear", {31'h0, load_err}, 32'h0);
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter DEPTH, default 1024, number of 16-bit words; power of two, at most 8192.
REQ-002 Parameter AW, default 13, width of the address ports.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port wrEn  input  1  CPU write strobe.
REQ-006 Port addr_toRAM  input  AW  CPU word address.
REQ-007 Port data_toRAM  input  16  CPU write data.
REQ-008 Port data_fromRAM  output  16  registered read data to the CPU.
REQ-009 Port load_valid  input  1  loader word valid.
REQ-010 Port load_data  input  16  loader program word.
REQ-011 Port load_last  input  1  marks the final loader word; qualified by load_valid.
REQ-012 Port load_ready  output  1  responder accepts a loader word this cycle.
REQ-013 Port cpu_rst  output  1  reset for the CPU, held high until the program is loaded.
REQ-014 Port load_count  output  AW+1  number of words accepted in the current load.
REQ-015 Port load_err  output  1  sticky flag: the load overflowed DEPTH.

Function
REQ-016 The FSM SHALL have three states: LOAD, START and RUN.
REQ-017 LOAD: load_ready=1 and cpu_rst=1; the CPU port is ignored; data_fromRAM holds 0.
REQ-018 A handshake is load_valid & load_ready on a rising edge.
  - The edge writes mem[ptr] <= load_data.
  - It increments ptr and load_count.
REQ-019 A handshake with load_last=1 SHALL move the FSM LOAD->START.
REQ-020 A handshake that writes index DEPTH-1 with load_last=0 SHALL set load_err=1 and move LOAD->START.
REQ-021 START: lasts exactly one cycle.
  - load_ready=0 and cpu_rst=1, so the CPU samples reset on at least one edge after the last word.
  - Then START->RUN unconditionally.
REQ-022 RUN: load_ready=0 and cpu_rst=0; the FSM stays in RUN until rst.
REQ-023 RUN read: on every edge, data_fromRAM <= mem[addr_toRAM mod DEPTH].
  - One-cycle latency: the address presented in cycle n gives data valid throughout cycle n+1.
REQ-024 RUN write: on an edge with wrEn=1, mem[addr_toRAM mod DEPTH] <= data_toRAM.
REQ-025 Same-edge read and write to one address SHALL be read-before-write: data_fromRAM returns the old word, and the new word is visible from the next read.
REQ-026 Address bits above log2(DEPTH) SHALL be ignored, so addresses wrap modulo DEPTH.
REQ-027 load_valid and load_data SHALL be ignored outside LOAD.
REQ-028 Words in memory not written by the loader or the CPU SHALL read as 0, via a zero initial content.
REQ-029 Memory contents SHALL NOT be cleared by rst.
REQ-030 load_count SHALL saturate at DEPTH and hold its value through START and RUN.

Reset
REQ-031 While rst=1 the outputs SHALL be:
  - FSM in LOAD, ptr=0;
  - load_count=0, load_err=0, data_fromRAM=0;
  - cpu_rst=1, load_ready=1.
  - These values take effect asynchronously on assertion of rst.
REQ-032 rst asserted mid-load or mid-run SHALL abort immediately.
  - The FSM returns to LOAD with ptr=0.
  - A new load overwrites memory from address 0.
  - Words already written and not overwritten are retained.
REQ-033 On the first edge after rst deasserts, a valid word SHALL be accepted into address 0.

Verification
REQ-034 Load and start: load words 0x2005, 0xE000, 0x1234 with load_last on the third -> load_count=3; cpu_rst=1 for exactly one cycle after the last handshake; then RUN with cpu_rst=0.
REQ-035 Read latency: in RUN, present addr 2 in cycle n -> data_fromRAM=0x1234 in cycle n+1; present addr 1 in cycle n+1 -> data_fromRAM=0xE000 in cycle n+2.
REQ-036 Write collision: in RUN, wrEn=1, addr 5, data 0xBEEF with mem[5]=0 -> data_fromRAM=0 on the next cycle; a read of addr 5 on the following edge returns 0xBEEF.
REQ-037 Overflow and wrap with DEPTH=16:
  - Load 16 words without load_last -> load_err=1, load_count=16, RUN.
  - Read addr 0x0013 -> returns word 3.
REQ-038 Reset mid-load and ignored input:
  - Assert rst after 2 of 4 words, then reload 0xAAAA with load_last -> mem[0]=0xAAAA and mem[1] keeps its old value.
  - In RUN, load_valid=1 with data 0x5555 -> memory unchanged and load_ready=0.
